// File: rtl/card_table_ctrl.sv
// card_table_ctrl: card table (2-bit state + colour per card) with a
// round-robin write arbiter (colour loader vs game FSM), a registered lookup
// port and a valid/ready sweep streaming the whole table to the renderer.
// Optional macro CARD_TABLE_CLEAR_EN adds clr_start/clr_busy and a CLEAR
// state that reinitialises the table one entry per cycle.
module card_table_ctrl #(
  parameter int N_CARDS = 16,
  parameter int ADDR_W  = 4,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               col_req,
  input  logic [ADDR_W-1:0]  col_addr,
  input  logic [COLOR_W-1:0] col_data,
  output logic               col_gnt,
  input  logic               st_req,
  input  logic [ADDR_W-1:0]  st_addr,
  input  logic [1:0]         st_data,
  output logic               st_gnt,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [1:0]         rd_state,
  output logic [COLOR_W-1:0] rd_color,
  input  logic               upd_start,
  output logic               upd_busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [1:0]         out_state,
  output logic [COLOR_W-1:0] out_color,
`ifdef CARD_TABLE_CLEAR_EN
  input  logic               clr_start,
  output logic               clr_busy,
`endif
  output logic               upd_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP
`ifdef CARD_TABLE_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  state_t state, state_nxt;

  logic [1:0]         tbl_state [N_CARDS];
  logic [COLOR_W-1:0] tbl_color [N_CARDS];

  logic [ADDR_W-1:0]  addr_nxt;
  logic               done_nxt;
  logic               gnt_block;
  logic               prefer_st;
  logic [1:0]         rd_state_nxt;
  logic [COLOR_W-1:0] rd_color_nxt;
`ifdef CARD_TABLE_CLEAR_EN
  logic [ADDR_W-1:0]  clr_idx, clr_idx_nxt;
`endif

  // Round-robin grant: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    col_gnt = !gnt_block && col_req && (!st_req || !prefer_st);
    st_gnt  = !gnt_block && st_req  && (!col_req || prefer_st);
  end

  // Arbiter pointer moves only when a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       prefer_st <= 1'b0;
    else if (col_gnt) prefer_st <= 1'b1;
    else if (st_gnt)  prefer_st <= 1'b0;
  end

  // Table storage; addresses with no matching entry are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CARDS; i++) begin
        tbl_state[i] <= 2'b01;
        tbl_color[i] <= '0;
      end
    end else begin
`ifdef CARD_TABLE_CLEAR_EN
      // Grants are blocked in CLEAR, so the clear write never collides with a port write.
      if (state == S_CLEAR) begin
        for (int unsigned i = 0; i < N_CARDS; i++) begin
          if (clr_idx == ADDR_W'(i)) begin
            tbl_state[i] <= 2'b01;
            tbl_color[i] <= '0;
          end
        end
      end
`endif
      for (int unsigned i = 0; i < N_CARDS; i++) begin
        if (col_gnt && col_addr == ADDR_W'(i)) tbl_color[i] <= col_data;
        if (st_gnt && st_addr == ADDR_W'(i))   tbl_state[i] <= st_data;
      end
    end
  end

  // Table muxes for the lookup port and the sweep stream.
  always_comb begin
    rd_state_nxt = 2'b01;
    rd_color_nxt = '0;
    out_state    = 2'b01;
    out_color    = '0;
    for (int unsigned i = 0; i < N_CARDS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_state_nxt = tbl_state[i];
        rd_color_nxt = tbl_color[i];
      end
      if (out_addr == ADDR_W'(i)) begin
        out_state = tbl_state[i];
        out_color = tbl_color[i];
      end
    end
  end

  // Registered lookup: samples the table as it stood before this edge's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= 2'b01;
      rd_color <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_color <= rd_color_nxt;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      out_addr <= '0;
      upd_done <= 1'b0;
`ifdef CARD_TABLE_CLEAR_EN
      clr_idx  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      out_addr <= addr_nxt;
      upd_done <= done_nxt;
`ifdef CARD_TABLE_CLEAR_EN
      clr_idx  <= clr_idx_nxt;
`endif
    end
  end

  // Next-state logic: sweep handshakes, optional clear walk, grant blocking.
  always_comb begin
    state_nxt = state;
    addr_nxt  = out_addr;
    done_nxt  = 1'b0;
    gnt_block = 1'b0;
`ifdef CARD_TABLE_CLEAR_EN
    clr_idx_nxt = clr_idx;
`endif
    case (state)
      S_IDLE: begin
`ifdef CARD_TABLE_CLEAR_EN
        // Grants are also held off in the accepting cycle so no write lands just before the clear.
        if (clr_start) begin
          state_nxt   = S_CLEAR;
          clr_idx_nxt = '0;
          gnt_block   = 1'b1;
        end else
`endif
        if (upd_start) begin
          state_nxt = S_SWEEP;
          addr_nxt  = '0;
        end
      end
      S_SWEEP: begin
        if (out_ready) begin
          if (out_addr == ADDR_W'(N_CARDS - 1)) begin
            state_nxt = S_IDLE;
            addr_nxt  = '0;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt = out_addr + 1'b1;
          end
        end
      end
`ifdef CARD_TABLE_CLEAR_EN
      S_CLEAR: begin
        gnt_block = 1'b1;
        if (clr_idx == ADDR_W'(N_CARDS - 1)) state_nxt = S_IDLE;
        else clr_idx_nxt = clr_idx + 1'b1;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  assign out_valid = (state == S_SWEEP);
  assign upd_busy  = (state == S_SWEEP);
`ifdef CARD_TABLE_CLEAR_EN
  assign clr_busy  = (state == S_CLEAR);
`endif

endmodule
